// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART transmit path: state encodings, data width
// and a width helper for counters.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_defs_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_PARITY,
    S_TX_STOP
  } tx_state_t;

  // Ceiling log2, never narrower than one bit so counters always exist.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: emits a one-cycle tick on the last cycle of every
// CLKS_PER_BIT-cycle bit period. A synchronous restart realigns the period
// to the acceptance of a new frame.
module baud_tick_gen
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary or on restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: accepts one byte per request while idle and sends it
// LSB-first as an 8N1/8N2 frame (8E1/8E2 when UART_TX_PARITY_EN is defined).
// All outputs come straight from flops so the line never glitches.
module uart_tx_serializer
  import uart_defs_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       is_transmitting,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = clog2_min1(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = (state == S_TX_IDLE) && transmit;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .tick   (tick)
  );

  // Frame sequencer: each state's bit goes onto tx at the edge that enters it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_TX_IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      tx_done         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_TX_IDLE: begin
          tx <= 1'b1;
          if (transmit) begin
            shift_reg       <= tx_byte;
            bit_cnt         <= '0;
            tx              <= 1'b0;
            is_transmitting <= 1'b1;
            state           <= S_TX_START;
`ifdef UART_TX_PARITY_EN
            parity_bit      <= ^tx_byte;
`endif
          end
        end
        S_TX_START: begin
          if (tick) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity_bit;
              state   <= S_TX_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_TX_STOP;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_TX_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= S_TX_STOP;
          end
        end
`endif
        S_TX_STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt         <= '0;
              is_transmitting <= 1'b0;
              tx_done         <= 1'b1;
              state           <= S_TX_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx              <= 1'b1;
          is_transmitting <= 1'b0;
          bit_cnt         <= '0;
          state           <= S_TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit engine answering the `transmit`/`tx_byte`/`is_transmitting` handshake driven by the string-transmission controller FSMs. It latches one byte per request, serializes it LSB-first as an 8N1 (or 8N2) frame on `tx`, and reports busy/done status. It replaces the transmit half of the shared uart core so the controller's S_WAIT/S_SEND/S_INCR sequencing works unchanged.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), which must be ≥ 2; otherwise elaboration fails.
- STOP_BITS, 1: number of stop bits, 1 or 2. Other values are an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- transmit  input  1  send request, level-sampled only in IDLE.
- tx_byte  input  8  data byte, sampled in the same cycle `transmit` is accepted.
- tx  output  1  serial line, registered, idle high.
- is_transmitting  output  1  high from the cycle after acceptance until the last stop bit completes.
- tx_done  output  1  one-cycle pulse when a frame finishes.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, is_transmitting=0, tx_done=0.
  - State=IDLE; baud counter, bit counter and shift register cleared.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - tx=1.
  - If transmit=1 at a clock edge: latch tx_byte into the shift register, go to START. Next cycle tx=0 and is_transmitting=1 (latency 1 clk).
  - transmit=0: stay in IDLE.
- START: hold tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit counter runs 0..7; shift right after each bit.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
- End of STOP:
  - Same edge: go to IDLE, is_transmitting→0, tx_done=1 for exactly 1 cycle.
- Frame length: (1+8+STOP_BITS)×CLKS_PER_BIT cycles, plus PARITY_EN adds one bit period.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Reset to 0 on acceptance.
- Inputs during a frame:
  - transmit asserted while busy is ignored; there is no queuing and no error.
  - tx_byte changes after acceptance have no effect.
- transmit held high continuously: the next frame is accepted in the first IDLE cycle. The minimum inter-frame gap is 1 clk of idle-high beyond the stop bit(s).
- Reset deasserted mid-frame is not possible because reset is asynchronous. Asserting reset mid-frame aborts immediately: tx=1, no tx_done.
- tx is glitch-free: driven from a flop, never combinational from the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Transmits an even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1 / 8E2.
- Undefined: no PARITY state, no parity logic is synthesized, frame is 8N1 / 8N2.

Decomposition:
- Shared package/include `uart_defs`:
  - State encodings S_TX_IDLE, S_TX_START, S_TX_DATA, S_TX_PARITY, S_TX_STOP.
  - DATA_BITS=8.
  - Clog2 helper for counter widths.
- One natural sub-module: `baud_tick_gen`.
  - Counter producing a 1-cycle bit-boundary tick every CLKS_PER_BIT cycles.
  - Has a synchronous restart input driven on frame acceptance.

Test Plan:
- Use CLK_FREQ=1000000, BAUD=100000, giving CLKS_PER_BIT=10.
- 1. Reset: hold reset=0 with transmit=1 and tx_byte=0xFF → tx=1, is_transmitting=0, tx_done=0 throughout. After release, a frame starts on the first edge.
- 2. Single byte: pulse transmit with tx_byte=0x48 ('H') → 1 clk later tx=0 for 10 clk, then bits 0,0,0,1,0,0,1,0 at 10 clk each, stop=1 for 10 clk. is_transmitting is high for exactly 100 clk; tx_done pulses once at clk 101.
- 3. Busy ignore: start 0x41, then assert transmit with 0x5A mid-DATA → line carries only 0x41; no second frame unless transmit is still high in IDLE.
- 4. Back-to-back: hold transmit=1, stepping tx_byte 0x48→0x49 on tx_done → two frames separated by exactly 1 idle-high clk; decoded bytes are 0x48 and 0x49.
- 5. Reset mid-frame: assert reset at bit 3 of 0x00 → tx=1 and is_transmitting=0 asynchronously (before the next edge); no tx_done. After release, a fresh 0x55 frame is correct.
- 6. With UART_TX_PARITY_EN and STOP_BITS=2:
  - 0x48 → parity bit 0; 0x49 → parity bit 1.
  - Frame length is 120 clk, and tx_done falls on the correct edge.
